// File: rtl/pvr_ol_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : pvr_ol_pkg
//  Brief   : Object-list walker state encoding, entry type codes, parameter
//            block word counts and entry classification helper.
//  Rev     : 1.0  initial release
// ============================================================================
package pvr_ol_pkg;

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_FETCH      = 3'd1,
      S_DECODE     = 3'd2,
      S_ISSUE      = 3'd3,
      S_WAIT_DRAWN = 3'd4,
      S_NEXT       = 3'd5,
      S_FINISH     = 3'd6
   } ol_state_e;

   // Strips only have bit31 clear; they are normalised to 3'b000 for decode.
   localparam logic [2:0] TYPE_STRIP    = 3'b000;
   localparam logic [2:0] TYPE_TRI_ARR  = 3'b100;
   localparam logic [2:0] TYPE_QUAD_ARR = 3'b101;
   localparam logic [2:0] TYPE_RESERVED = 3'b110;
   localparam logic [2:0] TYPE_LINK     = 3'b111;

   localparam int unsigned HDR_WORDS_BASE   = 3;
   localparam int unsigned HDR_WORDS_SHADOW = 2;
   localparam int unsigned VTX_WORDS_BASE   = 3;
   localparam int unsigned VTX_CNT_TRI      = 3;
   localparam int unsigned VTX_CNT_QUAD     = 4;

   function automatic logic [2:0] entry_type(input logic [31:0] word);
      return word[31] ? word[31:29] : TYPE_STRIP;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ol_stride_calc.sv
`default_nettype none
// ============================================================================
//  Module  : ol_stride_calc
//  Brief   : Byte distance between consecutive primitives of an array entry.
//  Rev     : 1.0  initial release
// ============================================================================
module ol_stride_calc
   import pvr_ol_pkg::*;
(
   input  logic [2:0]  i_skip,
   input  logic        i_shadow,
   input  logic        i_is_quad,
   output logic [11:0] o_stride
);

   logic [11:0] w_hdr_words;
   logic [11:0] w_skip_words;
   logic [11:0] w_vtx_words;
   logic [11:0] w_all_vtx_words;
   logic [11:0] w_total_words;

   assign w_hdr_words  = 12'(HDR_WORDS_BASE) + (i_shadow ? 12'(HDR_WORDS_SHADOW) : 12'd0);
   // skip*(1+shadow) is a plain shift because shadow is a single bit
   assign w_skip_words = i_shadow ? {8'd0, i_skip, 1'b0} : {9'd0, i_skip};
   assign w_vtx_words  = 12'(VTX_WORDS_BASE) + w_skip_words;

   assign w_all_vtx_words = i_is_quad ? 12'(w_vtx_words << 2)
                                      : 12'((w_vtx_words << 1) + w_vtx_words);
   assign w_total_words   = w_hdr_words + w_all_vtx_words;
   assign o_stride        = {w_total_words[9:0], 2'b00};

endmodule
`default_nettype wire

// File: rtl/ol_walker.sv
`default_nettype none
// ============================================================================
//  Module  : ol_walker
//  Brief   : Walks a VRAM object list and hands each primitive to the parser.
//  Rev     : 1.0  initial release
// ============================================================================
module ol_walker
   import pvr_ol_pkg::*;
#(
   parameter int MAX_ENTRIES = 4096,
   parameter int ADDR_W      = 24
)(
   input  logic              i_clock,
   input  logic              i_reset,
   input  logic              i_start,
   input  logic [ADDR_W-1:0] i_ol_base,
   input  logic [ADDR_W-1:0] i_param_base,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_overrun,
   output logic              o_vram_rd,
   output logic [ADDR_W-1:0] o_vram_addr,
   input  logic              i_vram_ack,
   input  logic [31:0]       i_vram_din,
   output logic [31:0]       o_opb_word,
   output logic [ADDR_W-1:0] o_poly_addr,
   output logic              o_render_poly,
   input  logic              i_poly_drawn
);

   localparam int CNT_W = $clog2(MAX_ENTRIES + 1);

   ol_state_e         r_state;
   ol_state_e         w_next_state;
   logic [ADDR_W-1:0] r_ol_ptr;
   logic [CNT_W-1:0]  r_entry_cnt;
   logic [3:0]        r_prim_cnt;
   logic [31:0]       r_opb_word;
   logic [ADDR_W-1:0] r_poly_addr;
   logic              r_overrun;

   logic [2:0]        w_type;
   logic              w_is_array;
   logic              w_strip_empty;
   logic              w_link_end;
   logic              w_cnt_last;
   logic              w_more_prims;
   logic [ADDR_W-1:0] w_poly_base;
   logic [ADDR_W-1:0] w_link_target;
   logic [11:0]       w_stride;

   assign w_type        = entry_type(r_opb_word);
   assign w_is_array    = (w_type == TYPE_TRI_ARR) || (w_type == TYPE_QUAD_ARR);
   assign w_strip_empty = (r_opb_word[30:25] == 6'd0);
   assign w_link_end    = r_opb_word[28];
   assign w_cnt_last    = (r_entry_cnt + CNT_W'(1)) == CNT_W'(MAX_ENTRIES);
   assign w_more_prims  = w_is_array && (r_prim_cnt < r_opb_word[28:25]);
   assign w_poly_base   = i_param_base + ADDR_W'({r_opb_word[20:0], 2'b00});
   assign w_link_target = ADDR_W'({r_opb_word[23:2], 2'b00});

   ol_stride_calc u_stride (
      .i_skip    (r_opb_word[23:21]),
      .i_shadow  (r_opb_word[24]),
      .i_is_quad (w_type == TYPE_QUAD_ARR),
      .o_stride  (w_stride)
   );

   always_ff @(posedge i_clock) begin
      if (i_reset) r_state <= S_IDLE;
      else         r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:   if (i_start) w_next_state = S_FETCH;
         S_FETCH:  if (i_vram_ack) w_next_state = S_DECODE;
         S_DECODE: begin
            case (w_type)
               TYPE_LINK:     w_next_state = (w_link_end || w_cnt_last) ? S_FINISH : S_FETCH;
               TYPE_TRI_ARR,
               TYPE_QUAD_ARR: w_next_state = S_ISSUE;
               TYPE_RESERVED: w_next_state = S_NEXT;
               default:       w_next_state = w_strip_empty ? S_NEXT : S_ISSUE;
            endcase
         end
         S_ISSUE:      w_next_state = S_WAIT_DRAWN;
         S_WAIT_DRAWN: if (i_poly_drawn) w_next_state = w_more_prims ? S_ISSUE : S_NEXT;
         S_NEXT:       w_next_state = w_cnt_last ? S_FINISH : S_FETCH;
         S_FINISH:     w_next_state = S_IDLE;
         default:      w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_ol_ptr    <= '0;
         r_entry_cnt <= '0;
         r_prim_cnt  <= '0;
         r_opb_word  <= '0;
         r_poly_addr <= '0;
         r_overrun   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: if (i_start) begin
               r_ol_ptr    <= i_ol_base;
               r_entry_cnt <= '0;
               r_overrun   <= 1'b0;
            end
            S_FETCH: if (i_vram_ack) r_opb_word <= i_vram_din;
            S_DECODE: begin
               if (w_type == TYPE_LINK) begin
                  if (!w_link_end) begin
                     if (w_cnt_last) begin
                        r_overrun <= 1'b1;
                     end else begin
                        r_ol_ptr    <= w_link_target;
                        r_entry_cnt <= r_entry_cnt + CNT_W'(1);
                     end
                  end
               end else if (w_is_array || (w_type == TYPE_STRIP && !w_strip_empty)) begin
                  r_prim_cnt  <= '0;
                  r_poly_addr <= w_poly_base;
               end
            end
            S_WAIT_DRAWN: if (i_poly_drawn && w_more_prims) begin
               r_prim_cnt  <= r_prim_cnt + 4'd1;
               r_poly_addr <= r_poly_addr + ADDR_W'(w_stride);
            end
            S_NEXT: begin
               if (w_cnt_last) begin
                  r_overrun <= 1'b1;
               end else begin
                  r_ol_ptr    <= r_ol_ptr + ADDR_W'(4);
                  r_entry_cnt <= r_entry_cnt + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // busy drops in the FINISH cycle so it falls together with the done pulse
   always_comb begin
      o_busy        = (r_state != S_IDLE) && (r_state != S_FINISH);
      o_done        = (r_state == S_FINISH);
      o_vram_rd     = (r_state == S_FETCH);
      o_render_poly = (r_state == S_ISSUE);
   end

   assign o_vram_addr = r_ol_ptr;
   assign o_opb_word  = r_opb_word;
   assign o_poly_addr = r_poly_addr;
   assign o_overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_ol_walker.sv
`default_nettype none
// ============================================================================
//  Module  : tb_ol_walker
//  Brief   : Directed, table-driven bench for the object-list walker.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_ol_walker;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [23:0] ol_base = '0;
   logic [23:0] param_base = '0;
   logic        busy, done, overrun, vram_rd, render_poly;
   logic [23:0] vram_addr, poly_addr;
   logic [31:0] opb_word;
   logic        vram_ack = 1'b0;
   logic [31:0] vram_din = '0;
   logic        poly_drawn = 1'b0;

   logic [11:0] st_out;
   logic [2:0]  st_skip = '0;
   logic        st_shadow = 1'b0;
   logic        st_quad = 1'b0;

   always #5 clk = ~clk;

   ol_walker #(.MAX_ENTRIES(4), .ADDR_W(24)) dut (
      .i_clock(clk), .i_reset(rst), .i_start(start),
      .i_ol_base(ol_base), .i_param_base(param_base),
      .o_busy(busy), .o_done(done), .o_overrun(overrun),
      .o_vram_rd(vram_rd), .o_vram_addr(vram_addr),
      .i_vram_ack(vram_ack), .i_vram_din(vram_din),
      .o_opb_word(opb_word), .o_poly_addr(poly_addr),
      .o_render_poly(render_poly), .i_poly_drawn(poly_drawn)
   );

   ol_stride_calc u_st (.i_skip(st_skip), .i_shadow(st_shadow), .i_is_quad(st_quad), .o_stride(st_out));

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- VRAM and parser models ----------------
   logic [31:0] mem [0:2047];
   logic [23:0] fq[$];
   logic [23:0] rq[$];
   int  ack_delay = 0;
   int  wait_cnt = 0;
   bit  in_fetch = 0;
   logic [23:0] held_addr = '0;
   int  stab_err = 0;
   int  rd_cycles = 0;
   int  done_cnt = 0;
   int  done_busy_err = 0;
   int  viol = 0;
   bit  outstanding = 0;
   int  dtimer = 0;
   bit  auto_drawn = 1;
   bit  man_drawn = 0;

   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            vram_ack = 0; poly_drawn = 0; wait_cnt = 0; in_fetch = 0; outstanding = 0;
         end else begin
            if (done) begin
               done_cnt++;
               if (busy) done_busy_err++;
            end
            if (render_poly) begin
               if (outstanding) viol++;
               rq.push_back(poly_addr);
               outstanding = 1;
               dtimer = 2;
            end
            if (vram_rd) rd_cycles++;
            if (vram_ack) begin
               vram_ack = 0;
            end else if (vram_rd) begin
               if (!in_fetch) begin
                  in_fetch = 1;
                  held_addr = vram_addr;
               end else if (vram_addr !== held_addr) begin
                  stab_err++;
               end
               if (wait_cnt == ack_delay) begin
                  vram_ack = 1;
                  vram_din = mem[vram_addr[12:2]];
                  fq.push_back(vram_addr);
                  wait_cnt = 0;
                  in_fetch = 0;
               end else begin
                  wait_cnt++;
               end
            end
            poly_drawn = 0;
            if (man_drawn) begin
               poly_drawn = 1;
               man_drawn = 0;
            end else if (auto_drawn && outstanding) begin
               if (dtimer == 0) begin
                  poly_drawn = 1;
                  outstanding = 0;
               end else begin
                  dtimer--;
               end
            end
         end
      end
   end

   // ---------------- vector tables ----------------
   typedef struct {
      logic [23:0]       base;
      logic [23:0]       pbase;
      logic [31:0]       w0;
      logic [31:0]       w1;
      int                n_fetch;
      logic [23:0]       f0;
      logic [23:0]       f1;
      int                n_rend;
      logic [2:0][23:0]  a;
      logic              ovr;
   } vec_t;

   typedef struct {
      logic [2:0]  skip;
      logic        shadow;
      logic        quad;
      logic [11:0] exp;
   } st_vec_t;

   vec_t    vecs[7];
   st_vec_t svecs[6];

   task automatic load(input vec_t v);
      for (int i = 0; i < 2048; i++) mem[i] = '0;
      mem[11'h400] = 32'hF000_0000;
      mem[v.base[12:2]]         = v.w0;
      mem[v.base[12:2] + 11'd1] = v.w1;
   endtask

   task automatic launch(input vec_t v);
      load(v);
      fq.delete(); rq.delete();
      done_cnt = 0; viol = 0; rd_cycles = 0; stab_err = 0; done_busy_err = 0;
      ol_base = v.base;
      param_base = v.pbase;
      @(negedge clk) start = 1;
      @(negedge clk) start = 0;
      chk("start_to_rd", {31'd0, vram_rd}, 32'd1);
   endtask

   task automatic wait_done();
      for (int k = 0; k < 3000 && done_cnt == 0; k++) @(negedge clk);
      repeat (3) @(negedge clk);
   endtask

   task automatic check_row(input int r, input vec_t v);
      string tag;
      tag = $sformatf("row%0d", r);
      chk({tag, "_done_cnt"}, done_cnt, 1);
      chk({tag, "_busy_at_done"}, done_busy_err, 0);
      chk({tag, "_n_fetch"}, fq.size(), v.n_fetch);
      if (fq.size() > 0) chk({tag, "_fetch0"}, {8'd0, fq[0]}, {8'd0, v.f0});
      if (fq.size() > 1 && v.n_fetch > 1) chk({tag, "_fetch1"}, {8'd0, fq[1]}, {8'd0, v.f1});
      chk({tag, "_n_render"}, rq.size(), v.n_rend);
      for (int i = 0; i < v.n_rend && i < rq.size(); i++)
         chk($sformatf("%s_poly_addr%0d", tag, i), {8'd0, rq[i]}, {8'd0, v.a[i]});
      chk({tag, "_overlap"}, viol, 0);
      chk({tag, "_overrun"}, {31'd0, overrun}, {31'd0, v.ovr});
      chk({tag, "_busy_idle"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      //            base      pbase      w0            w1        nf  f0        f1        nr  addrs (a[2],a[1],a[0])        ovr
      vecs[0] = '{24'h000000, 24'h100000, 32'h0800_0010, 32'hF000_0000, 2, 24'h000000, 24'h000004, 1, {24'h0, 24'h0, 24'h100040}, 1'b0};
      vecs[1] = '{24'h000040, 24'h000000, 32'hA140_0000, 32'hF000_0000, 2, 24'h000040, 24'h000044, 1, {24'h0, 24'h0, 24'h000000}, 1'b0};
      vecs[2] = '{24'h000080, 24'h000000, 32'h8400_0000, 32'hF000_0000, 2, 24'h000080, 24'h000084, 3, {24'h60, 24'h30, 24'h000000}, 1'b0};
      vecs[3] = '{24'h000200, 24'h000000, 32'hE000_1000, 32'h0000_0000, 2, 24'h000200, 24'h001000, 0, {24'h0, 24'h0, 24'h0}, 1'b0};
      vecs[4] = '{24'h000300, 24'h000000, 32'h0000_0000, 32'h0000_0000, 4, 24'h000300, 24'h000304, 0, {24'h0, 24'h0, 24'h0}, 1'b1};
      vecs[5] = '{24'h000380, 24'h000000, 32'hC000_0000, 32'hF000_0000, 2, 24'h000380, 24'h000384, 0, {24'h0, 24'h0, 24'h0}, 1'b0};
      // parameter address wraps past 2^24: 0xFFFFF0 + 0x20
      vecs[6] = '{24'h0003C0, 24'hFFFFF0, 32'h0200_0008, 32'hF000_0000, 2, 24'h0003C0, 24'h0003C4, 1, {24'h0, 24'h0, 24'h000010}, 1'b0};

      svecs[0] = '{3'd0, 1'b0, 1'b0, 12'd48};   // 4*(3+3*3)
      svecs[1] = '{3'd2, 1'b1, 1'b1, 12'd132};  // 4*(5+4*7)
      svecs[2] = '{3'd7, 1'b1, 1'b1, 12'd292};  // 4*(5+4*17)
      svecs[3] = '{3'd0, 1'b0, 1'b1, 12'd60};   // 4*(3+4*3)
      svecs[4] = '{3'd7, 1'b0, 1'b0, 12'd132};  // 4*(3+3*10)
      svecs[5] = '{3'd3, 1'b1, 1'b0, 12'd128};  // 4*(5+3*9)

      for (int i = 0; i < 6; i++) begin
         st_skip = svecs[i].skip; st_shadow = svecs[i].shadow; st_quad = svecs[i].quad;
         #1 chk($sformatf("stride%0d", i), {20'd0, st_out}, {20'd0, svecs[i].exp});
      end

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_done", {31'd0, done}, 0);
      chk("rst_overrun", {31'd0, overrun}, 0);
      chk("rst_vram_rd", {31'd0, vram_rd}, 0);
      chk("rst_render", {31'd0, render_poly}, 0);
      chk("rst_vram_addr", {8'd0, vram_addr}, 0);
      chk("rst_opb_word", opb_word, 0);
      chk("rst_poly_addr", {8'd0, poly_addr}, 0);
      rst = 0;
      repeat (2) @(negedge clk);

      for (int r = 0; r < 7; r++) begin
         launch(vecs[r]);
         wait_done();
         check_row(r, vecs[r]);
      end

      // VRAM back-pressure: ack 7 cycles late on every fetch
      ack_delay = 7;
      launch(vecs[0]);
      wait_done();
      ack_delay = 0;
      check_row(10, vecs[0]);
      chk("bp_addr_stable", stab_err, 0);
      chk("bp_rd_cycles", rd_cycles, 16);

      // reset while waiting for poly_drawn
      auto_drawn = 0;
      launch(vecs[0]);
      for (int k = 0; k < 200 && rq.size() == 0; k++) @(negedge clk);
      repeat (2) @(negedge clk);
      chk("wd_busy_before_reset", {31'd0, busy}, 1);
      chk("wd_poly_addr_held", {8'd0, poly_addr}, 32'h100040);
      rst = 1;
      @(negedge clk) rst = 0;
      chk("wd_busy_after_reset", {31'd0, busy}, 0);
      chk("wd_poly_addr_after_reset", {8'd0, poly_addr}, 0);
      chk("wd_opb_after_reset", opb_word, 0);
      chk("wd_ptr_after_reset", {8'd0, vram_addr}, 0);
      man_drawn = 1;
      repeat (4) @(negedge clk);
      chk("wd_late_drawn_busy", {31'd0, busy}, 0);
      chk("wd_late_drawn_render", rq.size(), 1);
      chk("wd_late_drawn_rd", {31'd0, vram_rd}, 0);
      chk("wd_late_drawn_done", done_cnt, 0);
      auto_drawn = 1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
